// File: rtl/dsky_relay_decoder_pkg.sv
`timescale 1ns/1ps
// Shared constants for the DSKY relay decoder: relay digit codes, table geometry and field widths.
package dsky_relay_decoder_pkg;

   localparam int NUM_ROWS = 12;
   localparam int ROW_W    = 4;
   localparam int WORD_W   = 11;
   localparam int CODE_W   = 5;
   localparam int RELAY_W  = ROW_W + WORD_W;

   localparam logic [CODE_W-1:0] CODE_BLANK = 5'd0;
   localparam logic [CODE_W-1:0] CODE_D0    = 5'd21;
   localparam logic [CODE_W-1:0] CODE_D1    = 5'd3;
   localparam logic [CODE_W-1:0] CODE_D2    = 5'd25;
   localparam logic [CODE_W-1:0] CODE_D3    = 5'd27;
   localparam logic [CODE_W-1:0] CODE_D4    = 5'd15;
   localparam logic [CODE_W-1:0] CODE_D5    = 5'd30;
   localparam logic [CODE_W-1:0] CODE_D6    = 5'd28;
   localparam logic [CODE_W-1:0] CODE_D7    = 5'd19;
   localparam logic [CODE_W-1:0] CODE_D8    = 5'd29;
   localparam logic [CODE_W-1:0] CODE_D9    = 5'd31;

   function automatic logic row_valid(input logic [ROW_W-1:0] row);
      return (row >= 4'd1) && (row <= 4'(NUM_ROWS));
   endfunction

endpackage

// File: rtl/dsky_relay_decoder_if.sv
`timescale 1ns/1ps
// Relay input, read port and commit status bundle of the DSKY relay decoder.
interface dsky_relay_decoder_if;
   import dsky_relay_decoder_pkg::*;

   logic [WORD_W-1:0] RLYB;
   logic [ROW_W-1:0]  RYWD;
   logic [ROW_W-1:0]  RD_ROW;
   logic [WORD_W-1:0] RD_DATA;
   logic              RD_SIGN;
   logic [3:0]        RD_DIGL;
   logic [3:0]        RD_DIGR;
   logic              RD_BLKL;
   logic              RD_BLKR;
   logic              UPD;
   logic [ROW_W-1:0]  UPD_ROW;
   logic              BAD_CODE;

   modport master (
      output RLYB, RYWD, RD_ROW,
      input  RD_DATA, RD_SIGN, RD_DIGL, RD_DIGR, RD_BLKL, RD_BLKR, UPD, UPD_ROW, BAD_CODE
   );

   modport slave (
      input  RLYB, RYWD, RD_ROW,
      output RD_DATA, RD_SIGN, RD_DIGL, RD_DIGR, RD_BLKL, RD_BLKR, UPD, UPD_ROW, BAD_CODE
   );

endinterface

// File: rtl/dsky_relay_decoder_digit.sv
`timescale 1ns/1ps
// Relay digit decoder: 5-bit relay code to BCD digit, blank flag and illegal flag.
// Purely combinational; illegal codes read as 4'hF so they stand out on the display path.
module relay_digit_decode
   import dsky_relay_decoder_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   output logic [3:0]        digit_o,
   output logic              blank_o,
   output logic              illegal_o
);

   always_comb begin
      digit_o   = 4'hF;
      blank_o   = 1'b0;
      illegal_o = 1'b0;
      case (code_i)
         CODE_BLANK: begin digit_o = 4'd0; blank_o = 1'b1; end
         CODE_D0:    digit_o = 4'd0;
         CODE_D1:    digit_o = 4'd1;
         CODE_D2:    digit_o = 4'd2;
         CODE_D3:    digit_o = 4'd3;
         CODE_D4:    digit_o = 4'd4;
         CODE_D5:    digit_o = 4'd5;
         CODE_D6:    digit_o = 4'd6;
         CODE_D7:    digit_o = 4'd7;
         CODE_D8:    digit_o = 4'd8;
         CODE_D9:    digit_o = 4'd9;
         default:    illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/dsky_relay_decoder.sv
`timescale 1ns/1ps
// DSKY relay decoder: synchronizes the asynchronous relay word, debounces it over STABLE_CYCLES
// and commits it once per stable episode into a 12-row table with a combinational read port.
module dsky_relay_decoder
   import dsky_relay_decoder_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic                 SIM_CLK,
   input  logic                 SIM_RST_n,
   dsky_relay_decoder_if.slave  bus
);

   localparam logic [3:0] STB = 4'(STABLE_CYCLES);

   logic [RELAY_W-1:0] sync1_q, w_q, wprev_q;
   logic [3:0]         cnt_q, cnt_d;
   logic [WORD_W-1:0]  tbl_q [NUM_ROWS];
   logic               upd_q, bad_q;
   logic [ROW_W-1:0]   upd_row_q;
   logic               commit_d;

   logic [ROW_W-1:0]   w_row;
   logic               cl_ill, cr_ill;
   logic [3:0]         cl_dig_unused, cr_dig_unused;
   logic               cl_blk_unused, cr_blk_unused;

   assign w_row = w_q[RELAY_W-1:WORD_W];

   // The commit fires on the transition into saturation, so a held word commits only once.
   always_comb begin
      cnt_d    = cnt_q;
      commit_d = 1'b0;
      if (w_q != wprev_q) begin
         cnt_d = 4'd0;
      end else if (cnt_q != STB) begin
         cnt_d    = cnt_q + 4'd1;
         commit_d = (cnt_q == STB - 4'd1) && row_valid(w_row);
      end
   end

   relay_digit_decode u_commit_l (
      .code_i(w_q[9:5]), .digit_o(cl_dig_unused), .blank_o(cl_blk_unused), .illegal_o(cl_ill)
   );
   relay_digit_decode u_commit_r (
      .code_i(w_q[4:0]), .digit_o(cr_dig_unused), .blank_o(cr_blk_unused), .illegal_o(cr_ill)
   );

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         sync1_q   <= '0;
         w_q       <= '0;
         wprev_q   <= '0;
         cnt_q     <= '0;
         upd_q     <= 1'b0;
         bad_q     <= 1'b0;
         upd_row_q <= '0;
         for (int i = 0; i < NUM_ROWS; i++) tbl_q[i] <= '0;
      end else begin
         sync1_q <= {bus.RYWD, bus.RLYB};
         w_q     <= sync1_q;
         wprev_q <= w_q;
         cnt_q   <= cnt_d;
         upd_q   <= commit_d;
         bad_q   <= commit_d && (cl_ill || cr_ill);
         if (commit_d) begin
            upd_row_q           <= w_row;
            tbl_q[w_row - 4'd1] <= w_q[WORD_W-1:0];
         end
      end
   end

   logic [WORD_W-1:0] rd_data;
   logic              rl_ill_unused, rr_ill_unused;
   logic [3:0]        rd_digl, rd_digr;
   logic              rd_blkl, rd_blkr;

   always_comb begin
      rd_data = '0;
      if (row_valid(bus.RD_ROW)) rd_data = tbl_q[bus.RD_ROW - 4'd1];
   end

   relay_digit_decode u_read_l (
      .code_i(rd_data[9:5]), .digit_o(rd_digl), .blank_o(rd_blkl), .illegal_o(rl_ill_unused)
   );
   relay_digit_decode u_read_r (
      .code_i(rd_data[4:0]), .digit_o(rd_digr), .blank_o(rd_blkr), .illegal_o(rr_ill_unused)
   );

   assign bus.RD_DATA  = rd_data;
   assign bus.RD_SIGN  = rd_data[10];
   assign bus.RD_DIGL  = rd_digl;
   assign bus.RD_DIGR  = rd_digr;
   assign bus.RD_BLKL  = rd_blkl;
   assign bus.RD_BLKR  = rd_blkr;
   assign bus.UPD      = upd_q;
   assign bus.UPD_ROW  = upd_row_q;
   assign bus.BAD_CODE = bad_q;

endmodule

// File: tb/tb_dsky_relay_decoder.sv
`timescale 1ns/1ps
// Bench for dsky_relay_decoder: directed scenarios plus random word episodes scored against
// a run-length model of the relay stream and a lookup-based digit reference.
module tb_dsky_relay_decoder;
   import dsky_relay_decoder_pkg::*;

   localparam int S = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #50 clk = ~clk;

   dsky_relay_decoder_if bus ();

   dsky_relay_decoder #(.STABLE_CYCLES(S)) dut (
      .SIM_CLK(clk),
      .SIM_RST_n(rst_n),
      .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   int legal_codes [10] = '{21, 3, 25, 27, 15, 30, 28, 19, 29, 31};

   logic [10:0] m_tbl [16];
   logic [14:0] m_last;
   int          m_run;
   logic [15:0] due [$];
   logic [3:0]  m_upd_row;
   int          upd_pulses, bad_pulses, last_upd_edge, edge_no;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void ref_dig(input logic [4:0] c, output logic [3:0] d,
                                   output logic b, output logic ill);
      d = 4'hF; b = 1'b0; ill = 1'b1;
      if (c == 5'd0) begin d = 4'd0; b = 1'b1; ill = 1'b0; end
      for (int i = 0; i < 10; i++)
         if (int'(c) == legal_codes[i]) begin d = 4'(i); ill = 1'b0; end
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_tbl[i] = '0;
      m_last = '0;
      m_run = 1;
      due.delete();
      m_upd_row = '0;
   endtask

   // One clock: present x, let the edge sample it, then score the strobes.
   task automatic cycle(input logic [14:0] x);
      logic [15:0] e;
      logic exp_v, exp_bad, il, ir, bl, br;
      logic [3:0] dl, dr;
      logic [14:0] w;
      {bus.RYWD, bus.RLYB} = x;
      @(posedge clk);
      if (x == m_last) m_run++; else m_run = 1;
      m_last = x;
      due.push_back({(m_run == S + 1) && (x[14:11] >= 4'd1) && (x[14:11] <= 4'd12), x});
      exp_v = 1'b0; exp_bad = 1'b0; w = '0;
      if (due.size() == 3) begin
         e = due.pop_front();
         exp_v = e[15];
         w = e[14:0];
      end
      if (exp_v) begin
         ref_dig(w[9:5], dl, bl, il);
         ref_dig(w[4:0], dr, br, ir);
         exp_bad = il | ir;
         m_tbl[w[14:11]] = w[10:0];
         m_upd_row = w[14:11];
      end
      #1;
      chk("upd", 32'(bus.UPD), 32'(exp_v));
      chk("upd_row", 32'(bus.UPD_ROW), 32'(m_upd_row));
      chk("bad_code", 32'(bus.BAD_CODE), 32'(exp_bad));
      if (bus.UPD) begin upd_pulses++; last_upd_edge = edge_no; end
      if (bus.UPD && bus.BAD_CODE) bad_pulses++;
      edge_no++;
   endtask

   task automatic check_rows();
      logic [3:0] dl, dr;
      logic bl, br, il, ir;
      for (int r = 0; r < 16; r++) begin
         bus.RD_ROW = 4'(r);
         #1;
         ref_dig(m_tbl[r][9:5], dl, bl, il);
         ref_dig(m_tbl[r][4:0], dr, br, ir);
         chk("rd_data", 32'(bus.RD_DATA), 32'(m_tbl[r]));
         chk("rd_sign", 32'(bus.RD_SIGN), 32'(m_tbl[r][10]));
         chk("rd_digl", 32'(bus.RD_DIGL), 32'(dl));
         chk("rd_digr", 32'(bus.RD_DIGR), 32'(dr));
         chk("rd_blkl", 32'(bus.RD_BLKL), 32'(bl));
         chk("rd_blkr", 32'(bus.RD_BLKR), 32'(br));
      end
   endtask

   function automatic logic [4:0] rand_code();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'(legal_codes[$urandom_range(0, 9)]);
   endfunction

   initial begin : main
      logic [14:0] wa, wb, pool [6];
      int p, e0;
      upd_pulses = 0; bad_pulses = 0; last_upd_edge = -1; edge_no = 0;
      bus.RLYB = '0; bus.RYWD = '0; bus.RD_ROW = '0;
      m_reset();
      #120;
      chk("rst_upd", 32'(bus.UPD), 32'd0);
      chk("rst_upd_row", 32'(bus.UPD_ROW), 32'd0);
      chk("rst_bad", 32'(bus.BAD_CODE), 32'd0);
      check_rows();
      @(negedge clk) rst_n = 1'b1;

      // Basic commit and latency: row 11, digits 0 and 1.
      wa = {4'd11, 11'b0_10101_00011};
      p = upd_pulses; e0 = edge_no;
      repeat (10) cycle(wa);
      chk("r22_pulses", 32'(upd_pulses - p), 32'd1);
      chk("r22_latency", 32'(last_upd_edge - e0), 32'd6);
      chk("r22_upd_row", 32'(bus.UPD_ROW), 32'd11);
      bus.RD_ROW = 4'd11; #1;
      chk("r22_digl", 32'(bus.RD_DIGL), 32'd0);
      chk("r22_digr", 32'(bus.RD_DIGR), 32'd1);
      chk("r22_sign", 32'(bus.RD_SIGN), 32'd0);

      // Chattering word never settles, then settles exactly once.
      wa = {4'd2, 11'b0_11001_11011};
      wb = {4'd2, 11'b0_01111_11110};
      p = upd_pulses;
      repeat (4) begin repeat (3) cycle(wa); repeat (3) cycle(wb); end
      chk("r23_toggle", 32'(upd_pulses - p), 32'd0);
      repeat (10) cycle(wa);
      chk("r23_hold", 32'(upd_pulses - p), 32'd1);

      // Out-of-range and idle rows never commit.
      p = upd_pulses;
      repeat (10) cycle({4'd13, 11'b1_11100_10011});
      repeat (10) cycle({4'd15, 11'b0_10011_11101});
      repeat (10) cycle(15'd0);
      chk("r24_pulses", 32'(upd_pulses - p), 32'd0);
      check_rows();

      // Illegal left digit: stored anyway and flagged on the commit cycle.
      p = bad_pulses;
      repeat (9) cycle({4'd5, 11'b1_00100_11111});
      chk("r25_bad", 32'(bad_pulses - p), 32'd1);
      bus.RD_ROW = 4'd5; #1;
      chk("r25_digl", 32'(bus.RD_DIGL), 32'hF);
      chk("r25_digr", 32'(bus.RD_DIGR), 32'd9);
      chk("r25_sign", 32'(bus.RD_SIGN), 32'd1);
      chk("r25_blkl", 32'(bus.RD_BLKL), 32'd0);

      // Reset in the middle of a window discards the pending word.
      wa = {4'd7, 11'b0_11100_10011};
      repeat (6) cycle(wa);
      p = upd_pulses;
      #10 rst_n = 1'b0;
      m_reset();
      #1;
      chk("r26_upd_in_rst", 32'(bus.UPD), 32'd0);
      check_rows();
      @(posedge clk); #1;
      chk("r26_upd_edge", 32'(bus.UPD), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      e0 = edge_no;
      repeat (10) cycle(wa);
      chk("r26_pulses", 32'(upd_pulses - p), 32'd1);
      chk("r26_latency", 32'(last_upd_edge - e0), 32'd6);

      // Same word after an idle interlude commits a second time.
      wa = {4'd3, 11'b0_11101_10101};
      p = upd_pulses;
      repeat (8) cycle(wa);
      repeat (8) cycle(15'd0);
      repeat (8) cycle(wa);
      chk("r27_pulses", 32'(upd_pulses - p), 32'd2);
      chk("r27_upd_row", 32'(bus.UPD_ROW), 32'd3);

      // Random episodes from a small pool so repeats and chatter both occur.
      for (int i = 0; i < 6; i++)
         pool[i] = {4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rand_code(), rand_code()};
      for (int s = 0; s < 60; s++) begin
         wa = pool[$urandom_range(0, 5)];
         repeat ($urandom_range(1, 8)) cycle(wa);
         if (s % 20 == 19) check_rows();
      end
      check_rows();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
